// File: rtl/sel_latch_bank_pkg.sv
// Shared definitions for the selectable-operation register bank:
// op encodings and the snapshot engine state type.
package sel_latch_bank_pkg;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SET  = 2'b01;
    localparam logic [1:0] OP_CLR  = 2'b10;
    localparam logic [1:0] OP_TOG  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_COPY = 2'b01,
        S_DONE = 2'b10
    } snap_state_e;

endpackage

// File: rtl/sel_latch_bank_cell.sv
// One WIDTH-bit storage word: async reset, synchronous clear, and an
// enabled load/set/clear/toggle update of the registered value.
module latch_cell
    import sel_latch_bank_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sync_clr,
    input  logic             en,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    always_comb begin
        value_d = value_q;
        case (op)
            OP_LOAD: value_d = din;
            OP_SET:  value_d = value_q | din;
            OP_CLR:  value_d = value_q & ~din;
            OP_TOG:  value_d = value_q ^ din;
            default: value_d = value_q;
        endcase
    end

    // Clear has priority over any write presented in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= '0;
        end else if (sync_clr) begin
            value_q <= '0;
        end else if (en) begin
            value_q <= value_d;
        end
    end

    assign q = value_q;

endmodule

// File: rtl/sel_latch_bank.sv
// Multi-channel register bank with per-channel op select, saturating write
// counter, and a one-channel-per-cycle snapshot engine into a shadow copy.
module sel_latch_bank
    import sel_latch_bank_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [WIDTH-1:0]              din,
    input  logic [$clog2(CHANNELS)-1:0]   ch_sel,
    input  logic                          wr_en,
    input  logic [1:0]                    op,
    input  logic                          sync_clr,
    input  logic                          snap_req,
    output logic [CHANNELS*WIDTH-1:0]     q,
    output logic [CHANNELS*WIDTH-1:0]     snap_q,
    output logic                          snap_valid,
    output logic                          busy,
    output logic [CNT_W-1:0]              wr_cnt
);

    localparam int unsigned SEL_W = $clog2(CHANNELS);
    localparam logic [SEL_W:0]   NUM_CH   = (SEL_W + 1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(CHANNELS - 1);

    logic                wr_accept;
    logic [CHANNELS-1:0] cell_en;

    // Out-of-range selects are possible when CHANNELS is not a power of two.
    assign wr_accept = wr_en && !sync_clr && ({1'b0, ch_sel} < NUM_CH);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_cell
        assign cell_en[i] = wr_accept && (ch_sel == SEL_W'(i));

        latch_cell #(
            .WIDTH (WIDTH)
        ) u_cell (
            .clk      (clk),
            .reset    (reset),
            .sync_clr (sync_clr),
            .en       (cell_en[i]),
            .op       (op),
            .din      (din),
            .q        (q[i*WIDTH +: WIDTH])
        );
    end

    logic [CNT_W-1:0] wr_cnt_q;
    logic [CNT_W-1:0] wr_cnt_d;

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        if (wr_accept && (wr_cnt_q != {CNT_W{1'b1}})) begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
        end
    end

    snap_state_e                state_q;
    snap_state_e                state_d;
    logic [SEL_W-1:0]           idx_q;
    logic [SEL_W-1:0]           idx_d;
    logic [CHANNELS*WIDTH-1:0]  snap_q_r;
    logic [CHANNELS*WIDTH-1:0]  snap_d;
    logic                       busy_q;
    logic                       valid_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q_r;
        case (state_q)
            S_IDLE: begin
                if (snap_req) begin
                    state_d = S_COPY;
                    idx_d   = '0;
                end
            end
            S_COPY: begin
                // Captures the pre-edge value, so a same-edge write is missed.
                snap_d[32'(idx_q)*WIDTH +: WIDTH] = q[32'(idx_q)*WIDTH +: WIDTH];
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + SEL_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            snap_q_r <= '0;
            wr_cnt_q <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            snap_q_r <= snap_d;
            wr_cnt_q <= wr_cnt_d;
            busy_q   <= (state_d != S_IDLE);
            valid_q  <= (state_d == S_DONE);
        end
    end

    assign snap_q     = snap_q_r;
    assign snap_valid = valid_q;
    assign busy       = busy_q;
    assign wr_cnt     = wr_cnt_q;

endmodule

// File: doc/sel_latch_bank.md
# sel_latch_bank

Parametrised multi-channel register bank replacing the single-bit `always` latch exercises with a clocked, selectable-operation storage array. Each of CHANNELS words can be written, bit-set, bit-cleared or toggled under a 2-bit op select. A handshaked snapshot engine copies the whole bank into a shadow output one channel per cycle. The block serves as the common state-holding element for later if-else/case lab designs.

## Interface
- WIDTH, 8, bits per channel (≥1)
- CHANNELS, 4, number of channels (≥2, need not be a power of two)
- CNT_W, 8, width of write counter
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- din  in  WIDTH  write data / bit mask
- ch_sel  in  $clog2(CHANNELS)  target channel
- wr_en  in  1  perform op on ch_sel this cycle
- op  in  2  00 LOAD (q=din), 01 SET (q|=din), 10 CLR (q&=~din), 11 TOG (q^=din)
- sync_clr  in  1  synchronous clear of all channels
- snap_req  in  1  start snapshot (sampled in IDLE only)
- q  out  CHANNELS*WIDTH  live channel contents, channel i at [i*WIDTH +: WIDTH]
- snap_q  out  CHANNELS*WIDTH  shadow copy, same packing
- snap_valid  out  1  one-cycle pulse: snapshot complete
- busy  out  1  snapshot in progress (COPY or DONE)
- wr_cnt  out  CNT_W  accepted writes, saturating

## Operation
- Reset: q, snap_q, wr_cnt all zero; snap_valid=0, busy=0; FSM IDLE, copy index 0.
- Write accepted when wr_en=1, sync_clr=0, ch_sel<CHANNELS; op applied to registered value of that channel; other channels hold.
- ch_sel ≥ CHANNELS: write ignored, not counted.
- sync_clr=1: all q channels → 0 at next edge; simultaneous write dropped and not counted; wr_cnt and snap_q unaffected.
- wr_cnt +1 per accepted write; holds at 2^CNT_W−1.
- FSM states: IDLE, COPY, DONE.
  - IDLE: snap_req=1 → COPY, idx=0. Otherwise stay.
  - COPY: each edge snap_q[idx] ← q[idx] (value before that edge, so a write on the same edge is not captured); idx+1; after idx=CHANNELS−1 → DONE, idx=0.
  - DONE: snap_valid=1 for this one cycle; → IDLE.
- snap_req while busy ignored (no queueing).
- Writes/sync_clr during COPY allowed; already-copied channels keep old snapshot values, uncopied channels get whatever q holds when reached.
- Reset mid-snapshot: abort, all outputs to reset values.

## Timing
- Write latency: 1 cycle (q updates on edge sampling wr_en).
- snap_req sampled at edge t0 → channel i copied at edge t0+1+i → DONE entered at edge t0+CHANNELS → snap_valid and snap_q complete in cycle after edge t0+CHANNELS.
- busy high from edge t0 until edge t0+CHANNELS+1; earliest accepted next snap_req sampled at edge t0+CHANNELS+1.
- All outputs registered; no combinational input-to-output paths.

## Structure
- Package sel_latch_bank_pkg: op encodings (OP_LOAD, OP_SET, OP_CLR, OP_TOG) and FSM state enum (S_IDLE, S_COPY, S_DONE).
- Sub-module latch_cell: one WIDTH-bit register with async reset, sync clear, enable and op decode (case on op); instantiated CHANNELS times via generate.
- Top holds channel decode, wr_cnt, snapshot FSM/index and snap_q.

## Test plan
- Reset then LOAD din=8'hA5 to ch2 → next cycle q ch2=8'hA5, others 0, wr_cnt=1.
- On ch1 holding 8'hF0: SET 8'h0F → 8'hFF; CLR 8'h3C → 8'hC3; TOG 8'hFF → 8'h3C; wr_cnt +3.
- CHANNELS=3, ch_sel=3 write → q unchanged, wr_cnt unchanged; sync_clr with wr_en same cycle → all q=0, wr_cnt unchanged.
- q={ch3..ch0}={44,33,22,11}, snap_req at t0, LOAD 8'h99 to ch0 and ch3 at edge t0+2 → snap_q={99,33,22,11}, snap_valid one cycle after edge t0+4, busy high 5 cycles, second snap_req at t0+2 ignored.
- Reset asserted at edge t0+2 mid-snapshot → busy=0, snap_q=0, snap_valid never pulses; CNT_W=2 after 5 writes → wr_cnt=3.
